ttl_scan_mux: RTL and testbench

Parametrised registered N:1 multiplexer with a built-in channel scanner. It is the next-generation replacement for the fixed dual 4:1 TTL mux models. Channel count and data width are generic, the output is registered, and the select comes from either an external bus (manual mode) or an internal dwell/scan counter (scan mode). Typical uses are time-multiplexed displays, register-file readout and bus sampling in the TTL-level datapath.

---
 rtl/ttl_mux_pkg.sv | 12 +
 rtl/ttl_scan_counter.sv | 76 +++++++
 rtl/ttl_scan_mux.sv | 69 ++++++
 tb/tb_ttl_scan_mux.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_mux_pkg.sv
// Shared constants and helpers for the scanning multiplexer family.
package ttl_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Select width needed to address a given number of channels.
   function automatic int sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/ttl_scan_counter.sv
// Channel scanner: dwell counter, current select and wrap pulse.
module ttl_scan_counter
   import ttl_mux_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 1,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mode,
   input  logic             hold,
   input  logic [SEL_W-1:0] sel,
   output logic [SEL_W-1:0] cur_sel,
   output logic             wrap
);

   localparam int               DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

   logic [DW_W-1:0]  r_d;
   logic [SEL_W-1:0] r_cur_sel;
   logic             r_wrap;
   logic             r_mode_q;

   logic [DW_W-1:0]  w_d_nxt;
   logic [SEL_W-1:0] w_sel_nxt;
   logic             w_wrap_nxt;

   // Next-state: manual follows sel, the scan-entry edge only clears the
   // dwell count, otherwise advance after DWELL unheld cycles.
   always_comb begin
      w_d_nxt    = r_d;
      w_sel_nxt  = r_cur_sel;
      w_wrap_nxt = 1'b0;
      if (mode == MODE_MANUAL) begin
         w_d_nxt   = '0;
         w_sel_nxt = sel;
      end else if (r_mode_q != MODE_SCAN) begin
         w_d_nxt = '0;
      end else if (!hold) begin
         if (r_d == DW_LAST) begin
            w_d_nxt = '0;
            // Out-of-range selects also fall through to channel 0 here.
            if (r_cur_sel >= SEL_LAST) begin
               w_sel_nxt  = '0;
               w_wrap_nxt = 1'b1;
            end else begin
               w_sel_nxt = r_cur_sel + 1'b1;
            end
         end else begin
            w_d_nxt = r_d + 1'b1;
         end
      end
   end

   // Scanner state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_d       <= '0;
         r_cur_sel <= '0;
         r_wrap    <= 1'b0;
         r_mode_q  <= MODE_MANUAL;
      end else begin
         r_d       <= w_d_nxt;
         r_cur_sel <= w_sel_nxt;
         r_wrap    <= w_wrap_nxt;
         r_mode_q  <= mode;
      end
   end

   assign cur_sel = r_cur_sel;
   assign wrap    = r_wrap;

endmodule

// File: rtl/ttl_scan_mux.sv
// Registered N:1 multiplexer with manual or scanned channel select.
module ttl_scan_mux
   import ttl_mux_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 1,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      hold,
   input  logic                      enable_n,
   input  logic [CHANNELS*WIDTH-1:0] in_flat,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_sel,
   output logic [SEL_W-1:0]          cur_sel,
   output logic                      wrap
);

   logic [SEL_W-1:0] w_cur_sel;
   logic [WIDTH-1:0] w_data;
   logic [WIDTH-1:0] r_out;
   logic [SEL_W-1:0] r_out_sel;

   ttl_scan_counter #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL)
   ) u_counter (
      .clock   (clock),
      .reset   (reset),
      .mode    (mode),
      .hold    (hold),
      .sel     (sel),
      .cur_sel (w_cur_sel),
      .wrap    (wrap)
   );

   // Channel select; selects with no matching channel yield zero.
   always_comb begin
      w_data = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (w_cur_sel == SEL_W'(c)) begin
            w_data = in_flat[c*WIDTH +: WIDTH];
         end
      end
      if (enable_n) begin
         w_data = '0;
      end
   end

   // Output register stage; out_sel tracks the select regardless of enable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out     <= '0;
         r_out_sel <= '0;
      end else begin
         r_out     <= w_data;
         r_out_sel <= w_cur_sel;
      end
   end

   assign out     = r_out;
   assign out_sel = r_out_sel;
   assign cur_sel = w_cur_sel;

endmodule

// File: tb/tb_ttl_scan_mux.sv
// Bench for ttl_scan_mux: three instances against a behavioural model.
module tb_ttl_scan_mux;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        mode     = 1'b0;
   logic        hold     = 1'b0;
   logic        enable_n = 1'b0;
   logic [1:0]  sel      = 2'd2;
   logic [15:0] flat4    = 16'hDCBA;

   logic [2:0][3:0] d_out;
   logic [2:0][1:0] d_osel;
   logic [2:0][1:0] d_cur;
   logic [2:0]      d_wrap;

   int errors  = 0;
   int checks  = 0;
   bit started = 0;

   // Instance 0: 4 channels, dwell 1; 1: 4 channels, dwell 3; 2: 3 channels, dwell 1.
   int CHS[3] = '{4, 4, 3};
   int DWS[3] = '{1, 3, 1};

   // Model state: current select, registered outputs, and scan progress
   // expressed as start channel plus unheld scan cycles since entry.
   int m_cur[3], m_out[3], m_osel[3], m_wrap[3];
   int m_act[3], m_start[3], m_steps[3];

   always #5 clock = ~clock;

   ttl_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u_a (
      .clock(clock), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
      .enable_n(enable_n), .in_flat(flat4), .out(d_out[0]), .out_sel(d_osel[0]),
      .cur_sel(d_cur[0]), .wrap(d_wrap[0]));

   ttl_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_b (
      .clock(clock), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
      .enable_n(enable_n), .in_flat(flat4), .out(d_out[1]), .out_sel(d_osel[1]),
      .cur_sel(d_cur[1]), .wrap(d_wrap[1]));

   ttl_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) u_c (
      .clock(clock), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
      .enable_n(enable_n), .in_flat(flat4[11:0]), .out(d_out[2]), .out_sel(d_osel[2]),
      .cur_sel(d_cur[2]), .wrap(d_wrap[2]));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Channel reached after k advances from a given start channel.
   function automatic int scan_pos(input int st, input int k, input int ch);
      if (st >= ch) return (k == 0) ? st : (k - 1) % ch;
      return (st + k) % ch;
   endfunction

   task automatic model_edge(input int i);
      int oc;
      oc = m_cur[i];
      m_out[i]  = (enable_n || oc >= CHS[i]) ? 0 : int'(flat4[oc*4 +: 4]);
      m_osel[i] = oc;
      m_wrap[i] = 0;
      if (!mode) begin
         m_cur[i] = int'(sel);
         m_act[i] = 0;
      end else if (m_act[i] == 0) begin
         m_act[i]   = 1;
         m_start[i] = oc;
         m_steps[i] = 0;
      end else if (!hold) begin
         m_steps[i]++;
         if (m_steps[i] % DWS[i] == 0) begin
            m_cur[i]  = scan_pos(m_start[i], m_steps[i] / DWS[i], CHS[i]);
            m_wrap[i] = (m_cur[i] == 0) ? 1 : 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            m_cur[i] = 0; m_out[i] = 0; m_osel[i] = 0; m_wrap[i] = 0;
            m_act[i] = 0; m_start[i] = 0; m_steps[i] = 0;
         end else begin
            model_edge(i);
         end
      end
   end

   // Cycle-by-cycle comparison of every instance against the model.
   initial forever begin
      @(negedge clock);
      if (started) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("out[%0d]", i),     int'(d_out[i]),  m_out[i]);
            chk($sformatf("out_sel[%0d]", i), int'(d_osel[i]), m_osel[i]);
            chk($sformatf("cur_sel[%0d]", i), int'(d_cur[i]),  m_cur[i]);
            chk($sformatf("wrap[%0d]", i),    int'(d_wrap[i]), m_wrap[i]);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      logic [1:0] val;
      logic [3:0] eo[5];
      int ew[5];
      int ec[4];
      int ewc[4];
      eo  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
      ew  = '{0, 0, 0, 1, 0};
      ec  = '{0, 1, 2, 0};
      ewc = '{1, 0, 0, 1};

      // Reset and manual select of channel 2.
      step(); step();
      started = 1;
      reset = 1'b0;
      step();
      chk("t1_cur_sel", int'(d_cur[0]), 2);
      step();
      chk("t1_out", int'(d_out[0]), 12);
      chk("t1_out_sel", int'(d_osel[0]), 2);
      chk("t1_model_out", m_out[0], 12);

      // Scan with dwell 1 starting from channel 0.
      sel = 2'd0;
      step(); step();
      mode = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t2_out_%0d", k), int'(d_out[0]), int'(eo[k]));
         chk($sformatf("t2_wrap_%0d", k), int'(d_wrap[0]), ew[k]);
      end

      // Dwell 3 with a 5-cycle hold in the middle of a dwell period.
      val = d_cur[1];
      n = 0;
      while (d_cur[1] == val && n < 10) begin step(); n++; end
      chk("t3_wait_adv", int'(n < 10), 1);
      val = d_cur[1];
      step(); n = 1;
      hold = 1'b1;
      repeat (5) step();
      n += 5;
      hold = 1'b0;
      while (d_cur[1] == val && n < 30) begin step(); n++; end
      chk("t3_channel_cycles", n, 8);

      // Output disabled while scanning.
      enable_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("t4_out_off_%0d", k), int'(d_out[0]), 0);
      end
      enable_n = 1'b0;
      step();
      chk("t4_out_on", int'(d_out[0]), 10 + m_osel[0]);

      // Out-of-range manual select on the 3-channel instance, then scan.
      mode = 1'b0;
      sel  = 2'd3;
      step(); step();
      chk("t5_out", int'(d_out[2]), 0);
      chk("t5_out_sel", int'(d_osel[2]), 3);
      mode = 1'b1;
      step();
      chk("t5_entry_cur", int'(d_cur[2]), 3);
      chk("t5_entry_wrap", int'(d_wrap[2]), 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t5_cur_%0d", k), int'(d_cur[2]), ec[k]);
         chk($sformatf("t5_wrap_%0d", k), int'(d_wrap[2]), ewc[k]);
      end

      // Asynchronous reset mid-scan.
      n = 0;
      while (d_cur[0] != 2'd2 && n < 10) begin step(); n++; end
      chk("t6_wait_sel2", int'(n < 10), 1);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t6_rst_out[%0d]", i), int'(d_out[i]), 0);
         chk($sformatf("t6_rst_cur[%0d]", i), int'(d_cur[i]), 0);
         chk($sformatf("t6_rst_osel[%0d]", i), int'(d_osel[i]), 0);
      end
      step();
      reset = 1'b0;
      step();
      chk("t6_restart_cur", int'(d_cur[0]), 0);
      chk("t6_restart_out", int'(d_out[0]), 10);
      step();
      chk("t6_next_cur", int'(d_cur[0]), 1);

      // Randomised operation including occasional mid-cycle resets.
      for (int k = 0; k < 600; k++) begin
         step();
         flat4    = 16'($urandom);
         sel      = 2'($urandom_range(0, 3));
         hold     = ($urandom_range(0, 3) == 0);
         enable_n = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b1;
            step();
            reset = 1'b0;
         end
      end
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
